// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the two-port RAM arbiter/responder.
// Contents: port_id_t (which requester port), default parameter values.
package ram_arb_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ADDR_WIDTH_DEF = 4;
  localparam int unsigned CNT_WIDTH_DEF  = 8;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_t;

endpackage

// File: rtl/ram_arb_responder_if.sv
// Request/response bundle for the two requester ports (A, B) of ram_arb_responder.
// master: requester side (drives req/we/addr/din, receives gnt/rvalid/dout).
// slave:  responder side (the RAM).
interface ram_arb_responder_if
  import ram_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
);

  logic                  req_a;
  logic                  we_a;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] din_a;
  logic                  gnt_a;
  logic                  rvalid_a;
  logic [DATA_WIDTH-1:0] dout_a;

  logic                  req_b;
  logic                  we_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] din_b;
  logic                  gnt_b;
  logic                  rvalid_b;
  logic [DATA_WIDTH-1:0] dout_b;

  modport master (
    output req_a, we_a, addr_a, din_a,
    input  gnt_a, rvalid_a, dout_a,
    output req_b, we_b, addr_b, din_b,
    input  gnt_b, rvalid_b, dout_b
  );

  modport slave (
    input  req_a, we_a, addr_a, din_a,
    output gnt_a, rvalid_a, dout_a,
    input  req_b, we_b, addr_b, din_b,
    output gnt_b, rvalid_b, dout_b
  );

endinterface

// File: rtl/ram_arb_rr.sv
// Two-request arbiter. Grants are combinational and forced low while rst_n is low.
// RAM_ARB_RR_EN defined: round-robin pointer, after a contested grant the loser
// gets priority next. Undefined: A always wins, no pointer state (and no clk port).
// Ports: clk (RR build only), rst_n, req_a, req_b -> gnt_a, gnt_b.
module ram_arb_rr
  import ram_arb_pkg::*;
(
`ifdef RAM_ARB_RR_EN
  input  logic clk,
`endif
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  logic a_wins;

`ifdef RAM_ARB_RR_EN
  port_id_t prio_q;
  port_id_t prio_d;

  // Priority pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= PORT_A;
    end else begin
      prio_q <= prio_d;
    end
  end

  // Only contested grants move the pointer, and it moves to the loser
  always_comb begin
    prio_d = prio_q;
    if (req_a && req_b) begin
      prio_d = a_wins ? PORT_B : PORT_A;
    end
  end

  assign a_wins = req_a && (!req_b || (prio_q == PORT_A));
`else
  assign a_wins = req_a;
`endif

  assign gnt_a = rst_n && a_wins;
  assign gnt_b = rst_n && req_b && !a_wins;

endmodule

// File: rtl/ram_arb_responder.sv
// Single-port RAM shared by two requester ports through a req/gnt handshake.
// Writes commit at the grant edge; reads return dout with a one-cycle rvalid pulse
// on the cycle after the grant. conflict_cnt counts cycles where both ports request
// and saturates at all-ones.
// Ports: clk, rst_n (async, active low), bus (slave side of ram_arb_responder_if),
//        conflict_cnt.
// Build option: RAM_ARB_RR_EN selects round-robin arbitration (default: A has priority).
module ram_arb_responder
  import ram_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
)(
  input  logic                 clk,
  input  logic                 rst_n,
  ram_arb_responder_if.slave   bus,
  output logic [CNT_WIDTH-1:0] conflict_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic                  gnt_a;
  logic                  gnt_b;
  logic                  rd_a;
  logic                  rd_b;
  logic                  rvalid_a_q;
  logic                  rvalid_b_q;
  logic [DATA_WIDTH-1:0] dout_a_q;
  logic [DATA_WIDTH-1:0] dout_b_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  ram_arb_rr u_arb (
`ifdef RAM_ARB_RR_EN
    .clk   (clk),
`endif
    .rst_n (rst_n),
    .req_a (bus.req_a),
    .req_b (bus.req_b),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  assign rd_a = gnt_a && !bus.we_a;
  assign rd_b = gnt_b && !bus.we_b;

  // RAM array: contents are not reset; grants are already gated by rst_n
  always_ff @(posedge clk) begin
    if (gnt_a && bus.we_a) begin
      mem[bus.addr_a] <= bus.din_a;
    end else if (gnt_b && bus.we_b) begin
      mem[bus.addr_b] <= bus.din_b;
    end
  end

  // Read response registers; dout holds until the next read on that port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      dout_a_q   <= '0;
      dout_b_q   <= '0;
    end else begin
      rvalid_a_q <= rd_a;
      rvalid_b_q <= rd_b;
      if (rd_a) begin
        dout_a_q <= mem[bus.addr_a];
      end
      if (rd_b) begin
        dout_b_q <= mem[bus.addr_b];
      end
    end
  end

  // Saturating conflict counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bus.req_a && bus.req_b && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign bus.gnt_a    = gnt_a;
  assign bus.gnt_b    = gnt_b;
  assign bus.rvalid_a = rvalid_a_q;
  assign bus.rvalid_b = rvalid_b_q;
  assign bus.dout_a   = dout_a_q;
  assign bus.dout_b   = dout_b_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_ram_arb_responder.sv
// Self-checking bench for ram_arb_responder: directed scenarios plus constrained
// random traffic, compared every cycle against a transaction-level reference model.
module tb_ram_arb_responder;
  import ram_arb_pkg::*;

  localparam int unsigned DW    = DATA_WIDTH_DEF;
  localparam int unsigned AW    = ADDR_WIDTH_DEF;
  localparam int unsigned CW    = CNT_WIDTH_DEF;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int          CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] conflict_cnt;

  always #5 clk = ~clk;

  ram_arb_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_arb_responder #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .conflict_cnt (conflict_cnt)
  );

  // Reference model state
  logic [DW-1:0] m_mem   [DEPTH];
  bit            m_known [DEPTH];
  logic          m_rv_a, m_rv_b;
  logic [DW-1:0] m_do_a, m_do_b;
  int            m_cnt;
  bit            m_b_turn;   // RR model: B holds priority for the next conflict

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit a_wins_conflict();
`ifdef RAM_ARB_RR_EN
    return !m_b_turn;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    m_rv_a = 1'b0; m_rv_b = 1'b0;
    m_do_a = '0;   m_do_b = '0;
    m_cnt = 0;     m_b_turn = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.req_a = 1'b0; bus.we_a = 1'b0; bus.addr_a = '0; bus.din_a = '0;
    bus.req_b = 1'b0; bus.we_b = 1'b0; bus.addr_b = '0; bus.din_b = '0;
  endtask

  // One bus cycle, entered and left at a falling edge
  task automatic cycle(input logic ra, input logic wa, input logic [AW-1:0] aa,
                       input logic [DW-1:0] da,
                       input logic rb, input logic wb, input logic [AW-1:0] ab,
                       input logic [DW-1:0] db,
                       output logic ga, output logic gb);
    logic ea, eb;
    bus.req_a = ra; bus.we_a = wa; bus.addr_a = aa; bus.din_a = da;
    bus.req_b = rb; bus.we_b = wb; bus.addr_b = ab; bus.din_b = db;
    ea = ra && (!rb || a_wins_conflict());
    eb = rb && !ea;
    #1;
    chk("gnt_a", 32'(bus.gnt_a), 32'(ea));
    chk("gnt_b", 32'(bus.gnt_b), 32'(eb));
    @(posedge clk);
    m_rv_a = ea && !wa;
    m_rv_b = eb && !wb;
    if (m_rv_a) m_do_a = m_mem[aa];
    if (m_rv_b) m_do_b = m_mem[ab];
    if (ea && wa) begin m_mem[aa] = da; m_known[aa] = 1'b1; end
    if (eb && wb) begin m_mem[ab] = db; m_known[ab] = 1'b1; end
    if (ra && rb) begin
      if (m_cnt < CMAX) m_cnt++;
      m_b_turn = ea;
    end
    #1;
    chk("rvalid_a", 32'(bus.rvalid_a), 32'(m_rv_a));
    chk("rvalid_b", 32'(bus.rvalid_b), 32'(m_rv_b));
    chk("dout_a", 32'(bus.dout_a), 32'(m_do_a));
    chk("dout_b", 32'(bus.dout_b), 32'(m_do_b));
    chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
    ga = ea;
    gb = eb;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    bus.req_a = 1'b1;
    bus.req_b = 1'b1;
    #1;
    chk("rst_gnt_a", 32'(bus.gnt_a), 32'd0);
    chk("rst_gnt_b", 32'(bus.gnt_b), 32'd0);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk("rst_rvalid_a", 32'(bus.rvalid_a), 32'd0);
    chk("rst_rvalid_b", 32'(bus.rvalid_b), 32'd0);
    chk("rst_dout_a", 32'(bus.dout_a), 32'd0);
    chk("rst_dout_b", 32'(bus.dout_b), 32'd0);
    chk("rst_cnt", 32'(conflict_cnt), 32'd0);
  endtask

  initial begin
    logic ga, gb;
    logic [1:0] seq;
    logic pa, pb;
    logic ra, wa, rb, wb;
    logic [AW-1:0] aa, ab;
    logic [DW-1:0] da, db;

    for (int i = 0; i < int'(DEPTH); i++) begin
      m_known[i] = 1'b0;
      m_mem[i] = '0;
    end
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // 1: A writes alone
    cycle(1'b1, 1'b1, AW'(1), 8'hA5, 1'b0, 1'b0, '0, '0, ga, gb);
    cycle(1'b1, 1'b1, AW'(2), 8'h5A, 1'b0, 1'b0, '0, '0, ga, gb);

    // 2: B reads the value A wrote; dout_b holds afterwards
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(2), '0, ga, gb);
    chk("t2_dout_b", 32'(bus.dout_b), 32'h5A);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, ga, gb);
    chk("t2_dout_b_hold", 32'(bus.dout_b), 32'h5A);

    // 3/4: four contested read cycles, then A drops
    do_reset();
    seq = '0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, AW'(1), '0, 1'b1, 1'b0, AW'(2), '0, ga, gb);
      if (i < 2) seq[i] = ga;
    end
    chk("t3_cnt", 32'(conflict_cnt), 32'd4);
`ifdef RAM_ARB_RR_EN
    chk("t3_first_two_grants_a", 32'(seq), 32'b01);
`else
    chk("t4_first_two_grants_a", 32'(seq), 32'b11);
`endif
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(2), '0, ga, gb);
    chk("t4_b_granted_after_a_drops", 32'(gb), 32'd1);

    // 5: B writes, A reads same address next cycle
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, AW'(3), 8'h3C, ga, gb);
    cycle(1'b1, 1'b0, AW'(3), '0, 1'b0, 1'b0, '0, '0, ga, gb);
    chk("t5_dout_a", 32'(bus.dout_a), 32'h3C);

    // Fill remaining addresses so random reads are defined
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!m_known[i]) cycle(1'b1, 1'b1, AW'(i), DW'($urandom), 1'b0, 1'b0, '0, '0, ga, gb);
    end

    // Random traffic; a losing requester keeps its request unchanged
    pa = 1'b0; pb = 1'b0;
    ra = 1'b0; wa = 1'b0; aa = '0; da = '0;
    rb = 1'b0; wb = 1'b0; ab = '0; db = '0;
    for (int i = 0; i < 200; i++) begin
      if (!pa) begin
        ra = 1'($urandom_range(0, 1)); wa = 1'($urandom_range(0, 1));
        aa = AW'($urandom); da = DW'($urandom);
      end
      if (!pb) begin
        rb = 1'($urandom_range(0, 1)); wb = 1'($urandom_range(0, 1));
        ab = AW'($urandom); db = DW'($urandom);
      end
      cycle(ra, wa, aa, da, rb, wb, ab, db, ga, gb);
      pa = ra && !ga;
      pb = rb && !gb;
    end
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, ga, gb);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, ga, gb);

    // 6: reset between read grant and response, plus a write attempted under reset
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = AW'(1);
    #1;
    chk("t6_gnt_a_before_rst", 32'(bus.gnt_a), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_gnt_a_in_rst", 32'(bus.gnt_a), 32'd0);
    @(posedge clk);
    #1;
    chk("t6_rvalid_a", 32'(bus.rvalid_a), 32'd0);
    chk("t6_dout_a", 32'(bus.dout_a), 32'd0);
    chk("t6_cnt", 32'(conflict_cnt), 32'd0);
    bus.we_a = 1'b1; bus.din_a = ~m_mem[1];
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    model_reset();
    cycle(1'b1, 1'b0, AW'(1), '0, 1'b0, 1'b0, '0, '0, ga, gb);
    chk("t6_rvalid_after_rst", 32'(bus.rvalid_a), 32'd1);

    // Saturation of the conflict counter
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 1'b0, AW'(1), '0, 1'b1, 1'b0, AW'(2), '0, ga, gb);
    end
    chk("t6_cnt_saturated", 32'(conflict_cnt), 32'hFF);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, ga, gb);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
